id_issue_queue: RTL and testbench
=================================

# id_issue_queue

Decoupled decode-and-issue stage between `if_id` and `ex`. It accepts fetched instructions over a valid/ready handshake and decodes each into a micro-op. Micro-ops are buffered in a parametrised FIFO and issued in order to `ex` through a register scoreboard that holds back RAW/WAW hazards. A jump flush from `ex` discards everything not yet issued.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `XLEN`, 32: instruction, address and immediate width.
- `NREG`, 32: integer registers tracked by the scoreboard.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush_i` in 1: jump flush from `ex`.
- `in_valid_i` in 1: fetch offers an instruction.
- `in_ready_o` out 1: the stage accepts this cycle.
- `inst_i` in XLEN: instruction word.
- `inst_addr_i` in XLEN: instruction address.
- `out_valid_o` out 1: head micro-op is issuable.
- `out_ready_i` in 1: `ex` takes the micro-op.
- `out_inst_o` out XLEN: raw instruction.
- `out_inst_addr_o` out XLEN: instruction address.
- `out_class_o` out 4: `uop_class_t` value.
- `out_imm_o` out XLEN: sign-extended immediate for the class.
- `out_rd_o`, `out_rs1_o`, `out_rs2_o` out 5: register indices; 0 when unused.
- `out_reg_we_o` out 1: integer writeback.
- `out_freg_we_o` out 1: FP writeback.
- `wb_valid_i` in 1: integer writeback retires.
- `wb_rd_i` in 5: register being retired.
- `count_o` out $clog2(DEPTH)+1: occupancy.

## Operation
- Decode happens on the push side; fields are stored per entry.
- Classes: ALU_I, ALU_R, MUL, DIV, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, CSR, FP, FLW, FSW, ILLEGAL.
- Unrecognised opcode/funct3/funct7 combinations decode to ILLEGAL with both write enables 0. ILLEGAL is still issued in order.
- Immediate formats:
  - I (ALU_I, LOAD, JALR, FLW, CSR): inst[31:20], sign-extended.
  - S (STORE, FSW): {inst[31:25], inst[11:7]}, sign-extended.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
  - U (LUI, AUIPC): {inst[31:12], 12'b0}.
  - All others: 0.
- `out_reg_we_o`=1 only if the class writes an integer register and rd≠0. DIV sets it; the divider returns through `wb_*`.
- Push condition: `in_valid_i && in_ready_o && !flush_i`.
- `in_ready_o` = !full, taken from the registered count. There is no full-time bypass, even when a pop happens the same cycle.
- Scoreboard: `busy[NREG]`, bit 0 hardwired to 0.
- Head is issuable when the FIFO is non-empty and none of the used rs1, used rs2, or rd (when `out_reg_we_o`) is busy. The check uses registered `busy` with no same-cycle writeback bypass.
- Pop condition: `out_valid_o && out_ready_i && !flush_i`.
  - A pop with `out_reg_we_o` sets `busy[rd]`.
  - `wb_valid_i` clears `busy[wb_rd_i]`.
  - If a set and a clear hit the same index in one cycle, the set wins.
- `flush_i`:
  - Empties the FIFO next cycle (pointers and count to 0).
  - Blocks any push and any pop that cycle.
  - Leaves the scoreboard untouched, because issued instructions still write back.

## Timing
- Reset: FIFO empty, `count_o`=0, `in_ready_o`=1, `out_valid_o`=0, `busy`=0, and every `out_*` data field reads 0.
- Latency: an instruction pushed in cycle N can issue in cycle N+1 at the earliest. There is no fall-through.
- Throughput: one push and one pop per cycle sustained. Push and pop in the same cycle leave `count_o` unchanged.
- Output fields are registered and stable while `out_valid_o`=1 and `out_ready_i`=0.
- Pointers wrap modulo DEPTH.
- A reset asserted mid-stream overrides flush, push, pop and writeback.

## Structure
- Shared package `id_pkg`: `uop_class_t` enum, opcode/funct3/funct7 constants, the `uop_t` struct (class, rd, rs1, rs2, imm, reg_we, freg_we, inst, addr).
- Sub-module `id_uop_decode`: purely combinational, `inst_i` → `uop_t`.
- FIFO and scoreboard are inline in `id_issue_queue`.

## Test plan
- Reset, then push `addi x1,x0,5` (0x00500093): next cycle `out_valid_o`=1, class ALU_I, rd=1, rs1=0, imm=5, `out_reg_we_o`=1.
- RAW hold:
  - Issue 0x00500093, then push `add x2,x1,x1` (0x00108133). `out_valid_o` stays 0 while `busy[1]`.
  - Assert `wb_valid_i` with `wb_rd_i`=1. `out_valid_o`=1 the following cycle.
- Fill DEPTH=4 with `out_ready_i`=0: `in_ready_o`=0 after the 4th push and `count_o`=4. A 5th offer is not accepted. One pop gives `count_o`=3 and `in_ready_o`=1.
- Flush with 3 entries queued and `in_valid_i`=1 in the same cycle: next cycle `count_o`=0 and `out_valid_o`=0. Any `busy` bit already set remains set.
- Same-cycle writeback clear and issue set of x5: `busy[5]` stays 1. A later instruction reading x5 is held.
- Decode sweep: 0xFFFFFFFF gives ILLEGAL with both write enables 0. `jal x1,-4` gives imm 0xFFFFFFFC. An instruction writing x0 gives `out_reg_we_o`=0 and no busy bit set.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode types for the decode/issue stage: micro-op classes, RV opcode fields
// and the per-entry micro-op record stored in the issue FIFO.
package id_pkg;

  localparam int ILEN = 32;

  typedef enum logic [3:0] {
    UOP_ALU_I   = 4'd0,
    UOP_ALU_R   = 4'd1,
    UOP_MUL     = 4'd2,
    UOP_DIV     = 4'd3,
    UOP_LOAD    = 4'd4,
    UOP_STORE   = 4'd5,
    UOP_BRANCH  = 4'd6,
    UOP_JAL     = 4'd7,
    UOP_JALR    = 4'd8,
    UOP_LUI     = 4'd9,
    UOP_AUIPC   = 4'd10,
    UOP_CSR     = 4'd11,
    UOP_FP      = 4'd12,
    UOP_FLW     = 4'd13,
    UOP_FSW     = 4'd14,
    UOP_ILLEGAL = 4'd15
  } uop_class_t;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_STORE_FP = 7'h27;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_OP_FP    = 7'h53;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    uop_class_t        uclass;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [ILEN-1:0]   imm;
    logic              reg_we;
    logic              freg_we;
    logic [ILEN-1:0]   inst;
    logic [ILEN-1:0]   addr;
  } uop_t;

  function automatic logic [ILEN-1:0] sext12(input logic [11:0] v);
    return {{(ILEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/id_uop_decode.sv
// Combinational instruction decoder: raw word to micro-op. Register indices only name
// integer registers (FP operands stay 0) so the scoreboard never sees false hazards.
module id_uop_decode
  import id_pkg::*;
(
  input  logic [ILEN-1:0] inst,
  input  logic [ILEN-1:0] addr,
  output uop_t            uop
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [ILEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  uop_class_t      uclass;
  logic [ILEN-1:0] imm;
  logic            wr_int, use_rs1, use_rs2, freg_we;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = sext12(inst[31:20]);
  assign imm_s = sext12({inst[31:25], inst[11:7]});
  assign imm_b = {{(ILEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{(ILEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};

  always_comb begin
    uclass  = UOP_ILLEGAL;
    imm     = '0;
    wr_int  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    freg_we = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        // shift-immediates only allow the base or arithmetic funct7
        if (!((funct3 == F3_SLL && funct7 != F7_BASE) ||
              (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT))) begin
          uclass  = UOP_ALU_I;
          imm     = imm_i;
          wr_int  = 1'b1;
          use_rs1 = 1'b1;
        end
      end
      OPC_OP: begin
        if (funct7 == F7_BASE || (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)))
          uclass = UOP_ALU_R;
        else if (funct7 == F7_MULDIV)
          uclass = funct3[2] ? UOP_DIV : UOP_MUL;
        if (uclass != UOP_ILLEGAL) begin
          wr_int  = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          uclass  = UOP_LOAD;
          imm     = imm_i;
          wr_int  = 1'b1;
          use_rs1 = 1'b1;
        end
      end
      OPC_STORE: begin
        if (!funct3[2] && funct3 != 3'b011) begin
          uclass  = UOP_STORE;
          imm     = imm_s;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3[2:1] != 2'b01) begin
          uclass  = UOP_BRANCH;
          imm     = imm_b;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end
      OPC_JAL: begin
        uclass = UOP_JAL;
        imm    = imm_j;
        wr_int = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == F3_ADD) begin
          uclass  = UOP_JALR;
          imm     = imm_i;
          wr_int  = 1'b1;
          use_rs1 = 1'b1;
        end
      end
      OPC_LUI: begin
        uclass = UOP_LUI;
        imm    = imm_u;
        wr_int = 1'b1;
      end
      OPC_AUIPC: begin
        uclass = UOP_AUIPC;
        imm    = imm_u;
        wr_int = 1'b1;
      end
      OPC_SYSTEM: begin
        // funct3[2] selects the uimm form, whose rs1 field is not a register
        if (funct3[1:0] != 2'b00) begin
          uclass  = UOP_CSR;
          imm     = imm_i;
          wr_int  = 1'b1;
          use_rs1 = !funct3[2];
        end
      end
      OPC_OP_FP: begin
        uclass  = UOP_FP;
        freg_we = 1'b1;
      end
      OPC_LOAD_FP: begin
        if (funct3 == F3_W) begin
          uclass  = UOP_FLW;
          imm     = imm_i;
          use_rs1 = 1'b1;
          freg_we = 1'b1;
        end
      end
      OPC_STORE_FP: begin
        if (funct3 == F3_W) begin
          uclass  = UOP_FSW;
          imm     = imm_s;
          use_rs1 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    uop         = '0;
    uop.uclass  = uclass;
    uop.rd      = wr_int  ? inst[11:7]  : 5'd0;
    uop.rs1     = use_rs1 ? inst[19:15] : 5'd0;
    uop.rs2     = use_rs2 ? inst[24:20] : 5'd0;
    uop.imm     = imm;
    uop.reg_we  = wr_int && (inst[11:7] != 5'd0);
    uop.freg_we = freg_we;
    uop.inst    = inst;
    uop.addr    = addr;
  end

endmodule

// File: rtl/id_issue_queue.sv
// Decode-and-issue stage: decoded micro-ops queue in a FIFO, issue in order past a register
// scoreboard. One cycle minimum push-to-issue; in_ready drops only on registered full.
module id_issue_queue
  import id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int NREG  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [XLEN-1:0]          inst_i,
  input  logic [XLEN-1:0]          inst_addr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_inst_o,
  output logic [XLEN-1:0]          out_inst_addr_o,
  output logic [3:0]               out_class_o,
  output logic [XLEN-1:0]          out_imm_o,
  output logic [4:0]               out_rd_o,
  output logic [4:0]               out_rs1_o,
  output logic [4:0]               out_rs2_o,
  output logic                     out_reg_we_o,
  output logic                     out_freg_we_o,
  input  logic                     wb_valid_i,
  input  logic [4:0]               wb_rd_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  uop_t            mem [DEPTH];
  uop_t            dec_uop;
  uop_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [NREG-1:0] busy, busy_nxt;
  logic            hazard, push, pop;

  id_uop_decode u_decode (
    .inst (inst_i),
    .addr (inst_addr_i),
    .uop  (dec_uop)
  );

  assign head = mem[rd_ptr];

  // unused operand fields decode to x0, whose busy bit never sets
  assign hazard = busy[head.rs1] | busy[head.rs2] | (head.reg_we & busy[head.rd]);

  assign in_ready_o  = (count != FULL_CNT);
  assign out_valid_o = (count != '0) && !hazard;
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_uop;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // issue-set is applied after writeback-clear so it wins on the same index
  always_comb begin
    busy_nxt = busy;
    if (wb_valid_i) busy_nxt[wb_rd_i] = 1'b0;
    if (pop && head.reg_we) busy_nxt[head.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign out_inst_o      = head.inst;
  assign out_inst_addr_o = head.addr;
  assign out_class_o     = head.uclass;
  assign out_imm_o       = head.imm;
  assign out_rd_o        = head.rd;
  assign out_rs1_o       = head.rs1;
  assign out_rs2_o       = head.rs2;
  assign out_reg_we_o    = head.reg_we;
  assign out_freg_we_o   = head.freg_we;
  assign count_o         = count;

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: directed scenarios then randomized traffic, all checked
// against a queue-and-bitmap reference model of the decode and issue rules.
module tb_id_issue_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;

  localparam int C_ALU_I = 0,  C_ALU_R = 1,  C_MUL = 2,   C_DIV = 3;
  localparam int C_LOAD  = 4,  C_STORE = 5,  C_BRANCH = 6, C_JAL = 7;
  localparam int C_JALR  = 8,  C_LUI = 9,    C_AUIPC = 10, C_CSR = 11;
  localparam int C_FP    = 12, C_FLW = 13,   C_FSW = 14,  C_ILL = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [XLEN-1:0] inst_i = '0;
  logic [XLEN-1:0] inst_addr_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [XLEN-1:0] out_inst_o, out_inst_addr_o, out_imm_o;
  logic [3:0]      out_class_o;
  logic [4:0]      out_rd_o, out_rs1_o, out_rs2_o;
  logic            out_reg_we_o, out_freg_we_o;
  logic            wb_valid_i = 1'b0;
  logic [4:0]      wb_rd_i = '0;
  logic [$clog2(DEPTH):0] count_o;

  always #5 clk = ~clk;

  id_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_inst_o(out_inst_o), .out_inst_addr_o(out_inst_addr_o),
    .out_class_o(out_class_o), .out_imm_o(out_imm_o),
    .out_rd_o(out_rd_o), .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
    .out_reg_we_o(out_reg_we_o), .out_freg_we_o(out_freg_we_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .count_o(count_o)
  );

  typedef struct {
    int          cls;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          reg_we, freg_we;
    logic [31:0] inst, addr;
  } exp_t;

  exp_t        q[$];
  bit          busy_m [32];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pc = 32'h0000_1000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] a);
    exp_t       e;
    int         c, v;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         int_wr, r1, r2;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'h13: c = ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20)) ? C_ILL : C_ALU_I;
      7'h33: begin
        if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) c = C_ALU_R;
        else if (f7 == 1) c = (f3 < 4) ? C_MUL : C_DIV;
        else c = C_ILL;
      end
      7'h03: c = (f3 == 3 || f3 > 5) ? C_ILL : C_LOAD;
      7'h23: c = (f3 <= 2) ? C_STORE : C_ILL;
      7'h63: c = (f3 == 2 || f3 == 3) ? C_ILL : C_BRANCH;
      7'h6f: c = C_JAL;
      7'h67: c = (f3 == 0) ? C_JALR : C_ILL;
      7'h37: c = C_LUI;
      7'h17: c = C_AUIPC;
      7'h73: c = (f3 == 0 || f3 == 4) ? C_ILL : C_CSR;
      7'h53: c = C_FP;
      7'h07: c = (f3 == 2) ? C_FLW : C_ILL;
      7'h27: c = (f3 == 2) ? C_FSW : C_ILL;
      default: c = C_ILL;
    endcase
    int_wr = c inside {C_ALU_I, C_ALU_R, C_MUL, C_DIV, C_LOAD, C_JAL, C_JALR, C_LUI, C_AUIPC, C_CSR};
    r1 = (c inside {C_ALU_I, C_ALU_R, C_MUL, C_DIV, C_LOAD, C_STORE, C_BRANCH, C_JALR, C_FLW, C_FSW})
         || (c == C_CSR && f3 < 4);
    r2 = c inside {C_ALU_R, C_MUL, C_DIV, C_STORE, C_BRANCH};
    if (c inside {C_ALU_I, C_LOAD, C_JALR, C_FLW, C_CSR})
      v = int'($signed(w[31:20]));
    else if (c inside {C_STORE, C_FSW})
      v = int'($signed(w[31:25])) * 32 + int'(w[11:7]);
    else if (c == C_BRANCH)
      v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    else if (c == C_JAL)
      v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    else if (c inside {C_LUI, C_AUIPC})
      v = int'(w & 32'hFFFF_F000);
    else
      v = 0;
    e.cls     = c;
    e.rd      = int_wr ? w[11:7] : 5'd0;
    e.rs1     = r1 ? w[19:15] : 5'd0;
    e.rs2     = r2 ? w[24:20] : 5'd0;
    e.imm     = 32'(v);
    e.reg_we  = int_wr && (w[11:7] != 0);
    e.freg_we = c inside {C_FP, C_FLW};
    e.inst    = w;
    e.addr    = a;
    return e;
  endfunction

  function automatic bit head_ready();
    if (q.size() == 0) return 1'b0;
    return !(busy_m[q[0].rs1] || busy_m[q[0].rs2] || (q[0].reg_we && busy_m[q[0].rd]));
  endfunction

  task automatic compare_model();
    check("count", 64'(count_o), 64'(q.size()));
    check("in_ready", in_ready_o, q.size() < DEPTH);
    check("out_valid", out_valid_o, head_ready());
    if (q.size() > 0) begin
      check("class", out_class_o, 64'(q[0].cls));
      check("rd", out_rd_o, q[0].rd);
      check("rs1", out_rs1_o, q[0].rs1);
      check("rs2", out_rs2_o, q[0].rs2);
      check("imm", out_imm_o, q[0].imm);
      check("reg_we", out_reg_we_o, q[0].reg_we);
      check("freg_we", out_freg_we_o, q[0].freg_we);
      check("inst", out_inst_o, q[0].inst);
      check("addr", out_inst_addr_o, q[0].addr);
    end
  endtask

  // applies the rules for the clock edge that follows the currently driven inputs
  task automatic advance_model();
    exp_t h;
    bit   pop, push;
    if (rst) begin
      q.delete();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      return;
    end
    pop  = head_ready() && out_ready_i && !flush_i;
    push = in_valid_i && (q.size() < DEPTH) && !flush_i;
    if (pop) h = q[0];
    if (flush_i) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_decode(inst_i, inst_addr_i));
    end
    if (wb_valid_i) busy_m[wb_rd_i] = 1'b0;
    if (pop && h.reg_we) busy_m[h.rd] = 1'b1;
  endtask

  task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit ordy,
                      input bit wv, input logic [4:0] wr, input bit fl);
    @(posedge clk);
    #1;
    rst = r; in_valid_i = iv; inst_i = ins; inst_addr_i = pc; out_ready_i = ordy;
    wb_valid_i = wv; wb_rd_i = wr; flush_i = fl;
    pc = pc + 32'd4;
    @(negedge clk);
    compare_model();
    advance_model();
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 32'h0, ordy, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic push_in(input logic [31:0] ins, input bit ordy);
    step(1'b0, 1'b1, ins, ordy, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic wb(input logic [4:0] r, input bit ordy);
    step(1'b0, 1'b0, 32'h0, ordy, 1'b1, r, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] op;
    logic [6:0] f7;
    case ($urandom_range(0, 14))
      0: op = 7'h13;  1: op = 7'h33;  2: op = 7'h03;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h6f;  6: op = 7'h67;  7: op = 7'h37;
      8: op = 7'h17;  9: op = 7'h73;  10: op = 7'h53; 11: op = 7'h07;
      12: op = 7'h27; default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), op};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rst_count", 64'(count_o), 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_fields", {out_inst_o, out_inst_addr_o}, 0);
    check("rst_fields2", {out_imm_o, out_class_o, out_rd_o, out_rs1_o, out_rs2_o,
                          out_reg_we_o, out_freg_we_o}, 0);

    // addi x1,x0,5 issues the cycle after it is pushed
    push_in(32'h0050_0093, 1'b0);
    idle(1'b0);
    check("addi_valid", out_valid_o, 1);
    check("addi_class", out_class_o, C_ALU_I);
    check("addi_rd", out_rd_o, 1);
    check("addi_rs1", out_rs1_o, 0);
    check("addi_imm", out_imm_o, 5);
    check("addi_we", out_reg_we_o, 1);

    // add x2,x1,x1 waits for x1 writeback
    push_in(32'h0010_8133, 1'b1);
    idle(1'b1);
    check("raw_hold", out_valid_o, 0);
    wb(5'd1, 1'b1);
    check("raw_hold_wb_cycle", out_valid_o, 0);
    idle(1'b1);
    check("raw_release", out_valid_o, 1);
    wb(5'd2, 1'b0);

    // leave x6 busy across a flush
    push_in(32'h0010_0313, 1'b1);
    idle(1'b1);
    for (int k = 1; k <= 4; k++) push_in((32'(k) << 20) | 32'h13, 1'b0);
    push_in(32'h0050_0013, 1'b0);
    check("full_count", 64'(count_o), 4);
    check("full_ready", in_ready_o, 0);
    idle(1'b1);
    check("no_fifth", 64'(count_o), 4);
    idle(1'b0);
    check("pop_count", 64'(count_o), 3);
    check("pop_ready", in_ready_o, 1);
    step(1'b0, 1'b1, 32'h0010_8133, 1'b1, 1'b0, 5'd0, 1'b1);
    idle(1'b0);
    check("flush_count", 64'(count_o), 0);
    check("flush_valid", out_valid_o, 0);
    push_in(32'h0003_03B3, 1'b1);
    idle(1'b1);
    check("busy_after_flush", out_valid_o, 0);
    wb(5'd6, 1'b1);
    idle(1'b1);
    check("x6_release", out_valid_o, 1);
    wb(5'd7, 1'b0);

    // issue of x5 coincides with a writeback of x5: set wins
    push_in(32'h0070_0293, 1'b0);
    idle(1'b0);
    check("x5_valid", out_valid_o, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 1'b0);
    push_in(32'h0002_8433, 1'b1);
    idle(1'b1);
    check("set_wins", out_valid_o, 0);
    idle(1'b1);
    check("set_wins_hold", out_valid_o, 0);
    wb(5'd5, 1'b1);
    idle(1'b1);
    wb(5'd8, 1'b0);

    // decode corner cases
    push_in(32'hFFFF_FFFF, 1'b0);
    idle(1'b0);
    check("ill_class", out_class_o, C_ILL);
    check("ill_we", {out_reg_we_o, out_freg_we_o}, 0);
    idle(1'b1);
    push_in(32'hFFDF_F0EF, 1'b0);
    idle(1'b0);
    check("jal_class", out_class_o, C_JAL);
    check("jal_imm", out_imm_o, 32'hFFFF_FFFC);
    idle(1'b1);
    wb(5'd1, 1'b0);
    push_in(32'h0030_0013, 1'b0);
    idle(1'b0);
    check("x0_we", out_reg_we_o, 0);
    idle(1'b1);

    for (int n = 0; n < 4000; n++) begin
      step(n == 2000, $urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
